register_file: RTL and testbench

- Architectural general-purpose register file of the unpipelined MIPS datapath.
- Two combinational read ports drive the ALU operands: read port 1 feeds ALU input A; read port 2 feeds the ALU-B mux.
- One synchronous write port takes the writeback value, which is the ALU result Y or a memory load via the upstream writeback mux.
- Register $0 is hardwired to zero. A third read-only debug port lets the bench observe architectural state.

---
 rtl/register_file.sv | 66 ++++++
 tb/tb_register_file.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// MIPS general-purpose register file: two operand read ports, one debug port, one write port.
// Optional write-through forwarding on the operand ports under REGFILE_WRITE_BYPASS_EN.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic [ADDR_WIDTH-1:0] DbgReg,
  output logic [DATA_WIDTH-1:0] DbgData
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  we;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic [DATA_WIDTH-1:0] rdd;

  assign we = RegWrite && (WriteReg != '0);

  // Entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[WriteReg] <= WriteData;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    rdd = '0;
    if (ReadReg1 != '0) rd1 = mem[ReadReg1];
    if (ReadReg2 != '0) rd2 = mem[ReadReg2];
    if (DbgReg != '0)   rdd = mem[DbgReg];
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  assign fwd1 = rst_n && we && (WriteReg == ReadReg1);
  assign fwd2 = rst_n && we && (WriteReg == ReadReg2);

  assign ReadData1 = fwd1 ? WriteData : rd1;
  assign ReadData2 = fwd2 ? WriteData : rd2;
`else
  assign ReadData1 = rd1;
  assign ReadData2 = rd2;
`endif

  assign DbgData = rdd;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table, corner sequences,
// and random traffic against an array model.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ReadReg1;
  logic [AW-1:0] ReadReg2;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;
  logic [AW-1:0] DbgReg;
  logic [DW-1:0] DbgData;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .DbgReg    (DbgReg),
    .DbgData   (DbgData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                    input logic [AW-1:0] ad);
    ReadReg1 = a1;
    ReadReg2 = a2;
    DbgReg   = ad;
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    RegWrite  = 1'b1;
    WriteReg  = a;
    WriteData = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [AW-1:0] rdbg;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic [DW-1:0] edbg;
  } vec_t;

  vec_t vecs [6];

  logic [DW-1:0] model [N];

  function automatic logic [DW-1:0] stored(input logic [AW-1:0] a);
    return (a == 0) ? '0 : model[a];
  endfunction

  initial begin
    vecs[0] = '{1, 8,  32'hDEADBEEF, 8, 31, 8, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{1, 31, 32'h00000001, 8, 31, 8, 32'hDEADBEEF, 32'h1, 32'hDEADBEEF};
    vecs[2] = '{1, 0,  32'hFFFFFFFF, 0, 0,  0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{1, 9,  32'hA5A5A5A5, 9, 0,  9, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5};
    vecs[4] = '{0, 9,  32'h12345678, 9, 9,  9, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[5] = '{1, 3,  32'h00000011, 3, 8,  3, 32'h11, 32'hDEADBEEF, 32'h11};

    rst_n = 1'b0;
    RegWrite = 1'b0;
    WriteReg = '0;
    WriteData = '0;
    ReadReg1 = '0;
    ReadReg2 = '0;
    DbgReg = '0;
    #12;
    rst_n = 1'b1;
    rd(5, 31, 7);
    check("reset_state_r1", ReadData1, 0);
    check("reset_state_r2", ReadData2, 0);
    check("reset_state_dbg", DbgData, 0);

    // Reset after arbitrary writes, no clock edge involved
    @(posedge clk);
    #1;
    wr(5, 32'hCAFE0005);
    wr(31, 32'hCAFE001F);
    rd(5, 31, 5);
    check("pre_reset_r1", ReadData1, 32'hCAFE0005);
    check("pre_reset_r2", ReadData2, 32'hCAFE001F);
    #2;
    rst_n = 1'b0;
    #1;
    foreach (vecs[k]) begin end
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] idx;
      idx = (i == 0) ? 5'd0 : (i == 1) ? 5'd5 : 5'd31;
      rd(idx, idx, idx);
      check($sformatf("async_reset_r1_%0d", idx), ReadData1, 0);
      check($sformatf("async_reset_r2_%0d", idx), ReadData2, 0);
      check($sformatf("async_reset_dbg_%0d", idx), DbgData, 0);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      RegWrite  = vecs[i].we;
      WriteReg  = vecs[i].wa;
      WriteData = vecs[i].wd;
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      rd(vecs[i].r1, vecs[i].r2, vecs[i].rdbg);
      check($sformatf("vec%0d_r1", i), ReadData1, vecs[i].e1);
      check($sformatf("vec%0d_r2", i), ReadData2, vecs[i].e2);
      check($sformatf("vec%0d_dbg", i), DbgData, vecs[i].edbg);
    end

    // $0 protection, before and after the edge
    RegWrite = 1'b1;
    WriteReg = 0;
    WriteData = 32'hFFFFFFFF;
    rd(0, 0, 0);
    check("zero_pre_r1", ReadData1, 0);
    check("zero_pre_r2", ReadData2, 0);
    check("zero_pre_dbg", DbgData, 0);
    @(posedge clk);
    #1;
    check("zero_post_r1", ReadData1, 0);
    check("zero_post_dbg", DbgData, 0);
    RegWrite = 1'b0;

    // Same-cycle read/write of $3 (holds 0x11)
    RegWrite = 1'b1;
    WriteReg = 3;
    WriteData = 32'h22;
    rd(3, 3, 3);
    check("rw_pre_r1", ReadData1, BYP ? 32'h22 : 32'h11);
    check("rw_pre_r2", ReadData2, BYP ? 32'h22 : 32'h11);
    check("rw_pre_dbg", DbgData, 32'h11);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    check("rw_post_r1", ReadData1, 32'h22);
    check("rw_post_r2", ReadData2, 32'h22);
    check("rw_post_dbg", DbgData, 32'h22);

    // Reset mid-cycle while a write to $4 is pending
    wr(4, 32'h44);
    rd(4, 4, 4);
    check("mid_pre_r1", ReadData1, 32'h44);
    RegWrite = 1'b1;
    WriteReg = 4;
    WriteData = 32'h4444;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_r1", ReadData1, 0);
    check("mid_rst_dbg", DbgData, 0);
    @(posedge clk);
    #1;
    check("mid_rst_edge_r2", ReadData2, 0);
    RegWrite = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_r1", ReadData1, 0);
    check("mid_rel_dbg", DbgData, 0);

    // Random traffic against the array model; reset left everything zero
    for (int i = 0; i < N; i++) model[i] = '0;
    for (int it = 0; it < 300; it++) begin
      logic [DW-1:0] x1;
      logic [DW-1:0] x2;
      logic          hit;
      RegWrite  = ($urandom_range(0, 3) != 0);
      WriteReg  = AW'($urandom_range(0, N - 1));
      WriteData = $urandom;
      ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg : AW'($urandom_range(0, N - 1));
      ReadReg2  = AW'($urandom_range(0, N - 1));
      DbgReg    = ($urandom_range(0, 3) == 0) ? WriteReg : AW'($urandom_range(0, N - 1));
      #1;
      hit = BYP && RegWrite && (WriteReg != 0);
      x1 = (hit && ReadReg1 == WriteReg) ? WriteData : stored(ReadReg1);
      x2 = (hit && ReadReg2 == WriteReg) ? WriteData : stored(ReadReg2);
      check($sformatf("rnd%0d_pre_r1", it), ReadData1, x1);
      check($sformatf("rnd%0d_pre_r2", it), ReadData2, x2);
      check($sformatf("rnd%0d_pre_dbg", it), DbgData, stored(DbgReg));
      @(posedge clk);
      if (RegWrite && WriteReg != 0) model[WriteReg] = WriteData;
      #1;
      check($sformatf("rnd%0d_post_r1", it), ReadData1, stored(ReadReg1));
      check($sformatf("rnd%0d_post_dbg", it), DbgData, stored(DbgReg));
    end
    RegWrite = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
